vga_scan_reader: RTL
====================

# vga_scan_reader

Display-side stage downstream of `PictureMemory`. Generates 640x480@60 Hz VGA timing from the 100 MHz system clock and produces the 25 MHz `pix_stb` used as `PictureMemory`'s `pixel_clk`. Drives `r_address` in raster order and aligns returned `rgb` words with sync and blanking through a fixed-depth pipeline. Drives the 4-bit-per-channel VGA pins.

## Interface

Parameters:
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch, in pixels
- `H_SYNC`, 96, horizontal sync width, in pixels
- `H_BP`, 48, horizontal back porch, in pixels
- `V_ACTIVE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vertical sync width, in lines
- `V_BP`, 33, vertical back porch, in lines
- `STB_DIV`, 4, `clk` cycles per pixel strobe
- `RD_LATENCY`, 2, `PictureMemory` read latency in pixel strobes, range 1..4

Ports:
- `clk`  in  1  100 MHz system clock
- `reset`  in  1  synchronous reset, active-high
- `pix_stb`  out  1  one-`clk` pulse every `STB_DIV` cycles; connects to `PictureMemory.pixel_clk`
- `r_address`  out  19  read address into `PictureMemory`
- `rgb`  in  18  pixel word from `PictureMemory`, packed as {R[5:0], G[5:0], B[5:0]}
- `done`  in  2  `PictureMemory` status; `done[1]`=1 means the image is fully loaded
- `vga_hs`, `vga_vs`  out  1  horizontal and vertical sync, active-low
- `vga_r`, `vga_g`, `vga_b`  out  4  colour outputs
- `frame_start`  out  1  one-`clk` pulse when the counters wrap to (0,0)

## Operation

Strobe divider:
- `div_cnt` counts 0..`STB_DIV`-1.
- `pix_stb` is registered and high for exactly one `clk` cycle when `div_cnt` = `STB_DIV`-1.

Raster counters (all state below advances only on cycles where `pix_stb`=1):
- `h_cnt` runs 0..799. It wraps to 0 and increments `v_cnt`.
- `v_cnt` runs 0..524. It wraps to 0.
- Active region: `h_cnt`<640 and `v_cnt`<480.
- Sync regions:
  - `hs_raw` is low for `h_cnt` 656..751.
  - `vs_raw` is low for `v_cnt` 490..491.

Address generation:
- On each advance into an active position:
  - If the next position is (0,0), `r_address` is set to 0.
  - Otherwise `r_address` increments by 1. Line ends need no special case (639 is followed by 640).
- Outside the active region, `r_address` holds its value.
- Result:
  - 0 at (0,0).
  - 307199 at (639,479), held through vertical blanking.
  - Returns to 0 at the wrap.

Alignment pipeline:
- The active, `hs_raw` and `vs_raw` flags pass through `RD_LATENCY` registers, each clocked on `pix_stb`.
- The output registers load on `pix_stb` from the last pipeline stage and from `rgb`:
  - `vga_r` = `rgb[17:14]`
  - `vga_g` = `rgb[11:8]`
  - `vga_b` = `rgb[5:2]`
- Colour outputs are forced to 0 whenever the delayed active flag is 0 or `display_en` is 0.

Display gating:
- `display_en` is latched from `done[1]` only on the strobe where the counters wrap to (0,0).
- Changes to `done` mid-frame are ignored until the next frame.
- `done[0]` is unused.
- Sync signals run regardless of `display_en`.

`frame_start` is registered and asserted in the same `clk` cycle as the `pix_stb` that wraps the counters to (0,0).

## Timing

Reset values (take effect at the next `clk` edge, overriding everything else, valid mid-frame too):
- `div_cnt`=0, `pix_stb`=0
- `h_cnt`=0, `v_cnt`=0, `r_address`=0
- `vga_hs`=1, `vga_vs`=1
- colour outputs = 0
- all pipeline stages inactive (sync stages = 1)
- `display_en`=0, `frame_start`=0

Strobe and raster timing:
- The first `pix_stb` after `reset` deasserts occurs on the `STB_DIV`-th rising edge. Period is `STB_DIV` clocks.
- Counters and `r_address` update in the `clk` cycle that has `pix_stb`=1. The new `r_address` is visible from the next cycle.
- The VGA outputs for counter position (h,v) appear exactly `RD_LATENCY` strobes after the counters reach (h,v).

Period figures:
- Line: 800 strobes = 3200 clocks.
- Frame: 420000 strobes = 1,680,000 clocks.
- `frame_start` period: 1,680,000 clocks.

Reset mid-frame: the raster restarts at (0,0) with display blanked for the first frame.

## Test plan

- **Reset and strobe:**
  - Stimulus: hold `reset` for 2 cycles, then release.
  - Required response: all outputs equal their reset values during reset; first `pix_stb` on the 4th edge after release, then every 4 clocks; `r_address`=0.
- **Line timing:**
  - Stimulus: run free for one line.
  - Required response: `vga_hs` low for 96 strobes, starting `RD_LATENCY` strobes after `h_cnt`=656; 800 strobes between successive falling edges.
- **Frame timing:**
  - Stimulus: run free for more than one frame.
  - Required response: `vga_vs` low for 2 lines (1600 strobes); `frame_start` spacing is exactly 1,680,000 clocks.
- **Address sequence:**
  - Stimulus: run free through one frame.
  - Required response: `r_address` is 0 at (0,0), 639 at (639,0), 640 at (0,1), 307199 at (639,479); it holds 307199 through blanking and is 0 after the wrap.
- **Gating:**
  - Stimulus: `done`=2'b00 at the first wrap, then `done`=2'b10 mid-frame, with `rgb`=18'h3FFFF throughout.
  - Required response: colour outputs are 0 for that entire frame. In the next frame they are 4'hF during active pixels and 0 during blanking.
- **Mid-frame reset:**
  - Stimulus: pulse `reset` for one cycle at `v_cnt`=200.
  - Required response: all outputs return to their reset values on the next edge; counters restart from (0,0); `frame_start` fires 420000 strobes later.

Source files
------------

// File: rtl/vga_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_reader
// Description : VGA raster timing generator and read-side aligner for the
//               picture memory. Divides the system clock into a pixel strobe,
//               walks the raster, issues read addresses in raster order and
//               delays sync/blank flags so they line up with returned pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int STB_DIV    = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_stb,
  output logic [18:0] r_address,
  input  logic [17:0] rgb,
  input  logic [1:0]  done,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DW      = (STB_DIV > 1) ? $clog2(STB_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(STB_DIV - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Registered state
  logic [DW-1:0]         div_cnt_q, div_cnt_d;
  logic                  pix_stb_q, pix_stb_d;
  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic [VW-1:0]         v_cnt_q, v_cnt_d;
  logic [18:0]           r_address_q, r_address_d;
  logic [RD_LATENCY-1:0] act_pipe_q, act_pipe_d;
  logic [RD_LATENCY-1:0] hs_pipe_q, hs_pipe_d;
  logic [RD_LATENCY-1:0] vs_pipe_q, vs_pipe_d;
  logic                  vga_hs_q, vga_hs_d;
  logic                  vga_vs_q, vga_vs_d;
  logic [3:0]            vga_r_q, vga_r_d;
  logic [3:0]            vga_g_q, vga_g_d;
  logic [3:0]            vga_b_q, vga_b_d;
  logic                  display_en_q, display_en_d;
  logic                  frame_start_q, frame_start_d;

  // Combinational helpers
  logic                  w_h_wrap;
  logic                  w_wrap;
  logic [HW-1:0]         w_h_nxt;
  logic [VW-1:0]         w_v_nxt;
  logic                  w_act_nxt;
  logic                  w_hs_nxt;
  logic                  w_vs_nxt;
  logic                  w_col_en;
  logic [RD_LATENCY-1:0] w_act_shift;
  logic [RD_LATENCY-1:0] w_hs_shift;
  logic [RD_LATENCY-1:0] w_vs_shift;
  logic                  w_unused;

  // Status bit 0 and the low colour bits are not used by a 4-bit DAC.
  assign w_unused = ^{done[0], rgb[13:12], rgb[7:6], rgb[1:0]};

  // Next raster position and the flags belonging to it
  always_comb begin
    w_h_wrap  = (h_cnt_q == H_LAST);
    w_wrap    = w_h_wrap && (v_cnt_q == V_LAST);
    w_h_nxt   = w_h_wrap ? '0 : h_cnt_q + HW'(1);
    w_v_nxt   = w_h_wrap ? ((v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1)) : v_cnt_q;
    w_act_nxt = (w_h_nxt < H_ACT_END) && (w_v_nxt < V_ACT_END);
    w_hs_nxt  = !((w_h_nxt >= HS_START) && (w_h_nxt < HS_END));
    w_vs_nxt  = !((w_v_nxt >= VS_START) && (w_v_nxt < VS_END));
    w_col_en  = act_pipe_q[RD_LATENCY-1] && display_en_q;
  end

  // The first delay stage loads alongside the counters, so a depth of
  // RD_LATENCY stages lands flags on the output exactly RD_LATENCY strobes on.
  if (RD_LATENCY == 1) begin : g_pipe_single
    assign w_act_shift = w_act_nxt;
    assign w_hs_shift  = w_hs_nxt;
    assign w_vs_shift  = w_vs_nxt;
  end else begin : g_pipe_multi
    assign w_act_shift = {act_pipe_q[RD_LATENCY-2:0], w_act_nxt};
    assign w_hs_shift  = {hs_pipe_q[RD_LATENCY-2:0], w_hs_nxt};
    assign w_vs_shift  = {vs_pipe_q[RD_LATENCY-2:0], w_vs_nxt};
  end

  // Next-state logic: divider every clock, raster and outputs on the strobe
  always_comb begin
    div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
    pix_stb_d     = (div_cnt_d == DIV_LAST);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    r_address_d   = r_address_q;
    act_pipe_d    = act_pipe_q;
    hs_pipe_d     = hs_pipe_q;
    vs_pipe_d     = vs_pipe_q;
    vga_hs_d      = vga_hs_q;
    vga_vs_d      = vga_vs_q;
    vga_r_d       = vga_r_q;
    vga_g_d       = vga_g_q;
    vga_b_d       = vga_b_q;
    display_en_d  = display_en_q;
    if (pix_stb_q) begin
      h_cnt_d    = w_h_nxt;
      v_cnt_d    = w_v_nxt;
      if (w_act_nxt) begin
        r_address_d = w_wrap ? '0 : r_address_q + 19'd1;
      end
      act_pipe_d = w_act_shift;
      hs_pipe_d  = w_hs_shift;
      vs_pipe_d  = w_vs_shift;
      vga_hs_d   = hs_pipe_q[RD_LATENCY-1];
      vga_vs_d   = vs_pipe_q[RD_LATENCY-1];
      vga_r_d    = w_col_en ? rgb[17:14] : 4'h0;
      vga_g_d    = w_col_en ? rgb[11:8]  : 4'h0;
      vga_b_d    = w_col_en ? rgb[5:2]   : 4'h0;
      // Image readiness is only sampled at frame boundaries to avoid tearing.
      if (w_wrap) begin
        display_en_d = done[1];
      end
    end
    // Flag the strobe cycle whose edge will carry the counters back to (0,0).
    frame_start_d = pix_stb_d && (h_cnt_d == H_LAST) && (v_cnt_d == V_LAST);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      pix_stb_q     <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      r_address_q   <= '0;
      act_pipe_q    <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      vga_r_q       <= 4'h0;
      vga_g_q       <= 4'h0;
      vga_b_q       <= 4'h0;
      display_en_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_stb_q     <= pix_stb_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      r_address_q   <= r_address_d;
      act_pipe_q    <= act_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      display_en_q  <= display_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_stb     = pix_stb_q;
  assign r_address   = r_address_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire
